// File: rtl/fan_duty_ctrl_if.sv
// Temperature-sample and fan-duty signals between the sensor/PWM side and fan_duty_ctrl.
// master drives the sample; slave (the controller) drives duty and status.
interface fan_duty_ctrl_if;
    logic       temp_valid;
    logic [7:0] temp_data;
    logic [7:0] fan_duty;
    logic       fail_safe;
    logic [7:0] temp_latched;

    modport master (
        output temp_valid,
        output temp_data,
        input  fan_duty,
        input  fail_safe,
        input  temp_latched
    );

    modport slave (
        input  temp_valid,
        input  temp_data,
        output fan_duty,
        output fail_safe,
        output temp_latched
    );
endinterface

// File: rtl/fan_duty_ctrl.sv
// Temperature-to-fan-duty controller: piecewise-linear curve, falling hysteresis,
// sensor-loss watchdog with full-speed fail-safe. FAN_SLEW_EN adds duty slew limiting.
module fan_duty_ctrl #(
    parameter int T_LOW         = 35,
    parameter int T_HIGH        = 70,
    parameter int DUTY_MIN      = 60,
    parameter int DUTY_MAX      = 222,
    parameter int DUTY_STEP     = 4,
    parameter int DUTY_INIT     = 150,
    parameter int HYST          = 3,
    parameter int TIMEOUT_TICKS = 6250000
`ifdef FAN_SLEW_EN
    ,
    parameter int SLEW_TICKS    = 7812
`endif
) (
    input  logic            clk0,
    input  logic            rstn,
    fan_duty_ctrl_if.slave  bus
);

    localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);

    localparam logic signed [8:0] T_LOW_S  = 9'(T_LOW);
    localparam logic signed [8:0] T_HIGH_S = 9'(T_HIGH);
    localparam logic signed [8:0] HYST_S   = 9'(HYST);
    localparam logic [9:0] DUTY_MIN_U  = 10'(DUTY_MIN);
    localparam logic [9:0] DUTY_MAX_U  = 10'(DUTY_MAX);
    localparam logic [9:0] DUTY_STEP_U = 10'(DUTY_STEP);
    localparam logic [9:0] T_LOW_U     = 10'(T_LOW);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FAILSAFE
    } state_t;

    state_t            state_q;
    logic [7:0]        fan_duty_q;
    logic              fail_safe_q;
    logic [7:0]        temp_latched_q;
    logic [WD_W-1:0]   wd_q;
    logic [1:0]        vcnt_q;

    logic              sample_ok;
    logic              sample_err;
    logic [WD_W-1:0]   wd_inc;
    logic              wd_expire;
    logic signed [8:0] lat_s;
    logic signed [8:0] new_s;
    logic              accept_new;
    logic [9:0]        ramp_u;
    logic [7:0]        target_duty;
    logic [7:0]        run_duty;

    assign sample_ok  = bus.temp_valid && (bus.temp_data != 8'h80);
    assign sample_err = bus.temp_valid && (bus.temp_data == 8'h80);

    assign wd_inc    = wd_q + WD_W'(1);
    assign wd_expire = (wd_inc == WD_W'(TIMEOUT_TICKS));

    // Sign-extend to 9 bits so the hysteresis threshold cannot wrap.
    assign lat_s      = {temp_latched_q[7], temp_latched_q};
    assign new_s      = {bus.temp_data[7], bus.temp_data};
    assign accept_new = (new_s > lat_s) || (new_s <= (lat_s - HYST_S));

    assign ramp_u = DUTY_MIN_U + (({2'b00, temp_latched_q} - T_LOW_U) * DUTY_STEP_U);

    always_comb begin
        target_duty = 8'(DUTY_MIN);
        if (lat_s <= T_LOW_S) begin
            target_duty = 8'(DUTY_MIN);
        end else if (lat_s >= T_HIGH_S) begin
            target_duty = 8'(DUTY_MAX);
        end else if (ramp_u > DUTY_MAX_U) begin
            target_duty = 8'(DUTY_MAX);
        end else begin
            target_duty = ramp_u[7:0];
        end
    end

`ifdef FAN_SLEW_EN
    localparam int SL_W = $clog2(SLEW_TICKS + 1);

    logic [SL_W-1:0] slew_q;
    logic [SL_W-1:0] slew_d;
    logic [SL_W-1:0] slew_inc;

    assign slew_inc = slew_q + SL_W'(1);

    // The step counter only runs while duty and target disagree; a reversal
    // keeps the count so the direction change lands on the next step.
    always_comb begin
        run_duty = fan_duty_q;
        slew_d   = '0;
        if (fan_duty_q != target_duty) begin
            if (slew_inc == SL_W'(SLEW_TICKS)) begin
                run_duty = (target_duty > fan_duty_q) ? (fan_duty_q + 8'd1)
                                                      : (fan_duty_q - 8'd1);
            end else begin
                slew_d = slew_inc;
            end
        end
    end

    always_ff @(posedge clk0 or negedge rstn) begin
        if (!rstn) begin
            slew_q <= '0;
        end else if (state_q == ST_RUN) begin
            slew_q <= slew_d;
        end else begin
            slew_q <= '0;
        end
    end
`else
    assign run_duty = target_duty;
`endif

    always_ff @(posedge clk0 or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_INIT;
            fan_duty_q     <= 8'(DUTY_INIT);
            fail_safe_q    <= 1'b0;
            temp_latched_q <= '0;
            wd_q           <= '0;
            vcnt_q         <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    fan_duty_q <= 8'(DUTY_INIT);
                    if (sample_ok) begin
                        temp_latched_q <= bus.temp_data;
                        wd_q           <= '0;
                        state_q        <= ST_RUN;
                    end else if (wd_expire) begin
                        state_q     <= ST_FAILSAFE;
                        fail_safe_q <= 1'b1;
                        fan_duty_q  <= 8'(DUTY_MAX);
                        wd_q        <= '0;
                        vcnt_q      <= '0;
                    end else begin
                        wd_q <= wd_inc;
                    end
                end
                ST_RUN: begin
                    fan_duty_q <= run_duty;
                    // A valid sample on the expiry cycle keeps us running.
                    if (sample_ok) begin
                        if (accept_new) begin
                            temp_latched_q <= bus.temp_data;
                        end
                        wd_q <= '0;
                    end else if (wd_expire) begin
                        state_q     <= ST_FAILSAFE;
                        fail_safe_q <= 1'b1;
                        fan_duty_q  <= 8'(DUTY_MAX);
                        wd_q        <= '0;
                        vcnt_q      <= '0;
                    end else begin
                        wd_q <= wd_inc;
                    end
                end
                ST_FAILSAFE: begin
                    fan_duty_q <= 8'(DUTY_MAX);
                    wd_q       <= '0;
                    if (sample_ok) begin
                        if (vcnt_q == 2'd1) begin
                            temp_latched_q <= bus.temp_data;
                            fail_safe_q    <= 1'b0;
                            vcnt_q         <= '0;
                            state_q        <= ST_RUN;
                        end else begin
                            vcnt_q <= vcnt_q + 2'd1;
                        end
                    end else if (sample_err) begin
                        vcnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.fan_duty     = fan_duty_q;
    assign bus.fail_safe    = fail_safe_q;
    assign bus.temp_latched = temp_latched_q;

endmodule

// File: tb/tb_fan_duty_ctrl.sv
// Directed bench for fan_duty_ctrl: an arithmetic reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_fan_duty_ctrl;

    localparam int TO = 200;
`ifdef FAN_SLEW_EN
    localparam int SL = 10;
`endif

    logic clk0 = 1'b0;
    logic rstn = 1'b0;
    always #5 clk0 = ~clk0;

    fan_duty_ctrl_if bus();

    fan_duty_ctrl #(
        .TIMEOUT_TICKS(TO)
`ifdef FAN_SLEW_EN
        ,
        .SLEW_TICKS(SL)
`endif
    ) dut (
        .clk0 (clk0),
        .rstn (rstn),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit chk_en      = 1'b0;

    always @(posedge clk0) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference curve straight from the temperature/duty rules.
    function automatic int curve(input int t);
        int v;
        if (t <= 35) return 60;
        if (t >= 70) return 222;
        v = 60 + (t - 35) * 4;
        return (v > 222) ? 222 : v;
    endfunction

    // mode: 0 = waiting for first reading, 1 = running, 2 = fail-safe
    int m_mode = 0;
    int m_lat  = 0;
    int m_duty = 150;
    int m_fs   = 0;
    int m_idle = 0;
    int m_cnt  = 0;
    int m_sc   = 0;

    always @(posedge clk0 or negedge rstn) begin : model
        int t, nd, nl, nmode, nfs, nidle, ncnt, nsc;
`ifdef FAN_SLEW_EN
        int tg;
`endif
        logic ok, err;
        if (!rstn) begin
            m_mode <= 0; m_lat <= 0; m_duty <= 150; m_fs <= 0;
            m_idle <= 0; m_cnt <= 0; m_sc <= 0;
        end else begin
            ok  = bus.temp_valid && (bus.temp_data != 8'h80);
            err = bus.temp_valid && (bus.temp_data == 8'h80);
            t   = int'($signed(bus.temp_data));
            nd = m_duty; nl = m_lat; nmode = m_mode; nfs = m_fs;
            nidle = m_idle; ncnt = m_cnt; nsc = m_sc;
            case (m_mode)
                0: begin
                    nd = 150; nsc = 0;
                    if (ok) begin
                        nl = t; nmode = 1; nidle = 0;
                    end else begin
                        nidle = m_idle + 1;
                        if (nidle == TO) begin
                            nmode = 2; nfs = 1; nd = 222; nidle = 0; ncnt = 0;
                        end
                    end
                end
                1: begin
`ifdef FAN_SLEW_EN
                    tg = curve(m_lat);
                    if (m_duty == tg) nsc = 0;
                    else begin
                        nsc = m_sc + 1;
                        if (nsc == SL) begin
                            nd  = (tg > m_duty) ? m_duty + 1 : m_duty - 1;
                            nsc = 0;
                        end
                    end
`else
                    nd = curve(m_lat);
`endif
                    if (ok) begin
                        if (t > m_lat || t <= m_lat - 3) nl = t;
                        nidle = 0;
                    end else begin
                        nidle = m_idle + 1;
                        if (nidle == TO) begin
                            nmode = 2; nfs = 1; nd = 222; nidle = 0; ncnt = 0;
                        end
                    end
                end
                default: begin
                    nd = 222; nsc = 0;
                    if (ok) begin
                        ncnt = m_cnt + 1;
                        if (ncnt == 2) begin
                            nl = t; nfs = 0; nmode = 1; ncnt = 0;
                        end
                    end else if (err) begin
                        ncnt = 0;
                    end
                end
            endcase
            m_duty <= nd; m_lat <= nl; m_mode <= nmode; m_fs <= nfs;
            m_idle <= nidle; m_cnt <= ncnt; m_sc <= nsc;
        end
    end

    always @(negedge clk0) begin
        if (chk_en) begin
            chk("model_duty", int'(bus.fan_duty), m_duty);
            chk("model_fs",   int'(bus.fail_safe), m_fs);
            chk("model_lat",  int'(bus.temp_latched), m_lat & 255);
        end
    end

    task automatic send(input logic [7:0] v);
        @(negedge clk0);
        bus.temp_valid = 1'b1;
        bus.temp_data  = v;
        $display("sample 0x%02h at cycle %0d", v, cyc);
        @(negedge clk0);
        bus.temp_valid = 1'b0;
        bus.temp_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk0);
    endtask

`ifdef FAN_SLEW_EN
    task automatic hold(input logic [7:0] v, input int n);
        repeat (n / 50) begin
            send(v);
            idle(48);
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL global_timeout: got cycle %0d, expected finish before", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int s, k;
        bus.temp_valid = 1'b0;
        bus.temp_data  = 8'h00;
        rstn = 1'b0;
        repeat (3) @(negedge clk0);
        chk_en = 1'b1;
        chk("rst_duty", int'(bus.fan_duty), 150);
        chk("rst_fs",   int'(bus.fail_safe), 0);
        chk("rst_lat",  int'(bus.temp_latched), 0);
        rstn = 1'b1;

`ifndef FAN_SLEW_EN
        send(8'h32);
        chk("first_lat", int'(bus.temp_latched), 50);
        chk("first_duty_n1", int'(bus.fan_duty), 150);
        idle(1);
        chk("first_duty_n2", int'(bus.fan_duty), 120);
        chk("first_fs", int'(bus.fail_safe), 0);

        send(8'd48); idle(1);
        chk("hyst_48_lat", int'(bus.temp_latched), 50);
        chk("hyst_48_duty", int'(bus.fan_duty), 120);
        send(8'd47);
        chk("hyst_47_lat", int'(bus.temp_latched), 47);
        idle(1);
        chk("hyst_47_duty", int'(bus.fan_duty), 108);
        send(8'd80); idle(1);
        chk("hot_80_duty", int'(bus.fan_duty), 222);
        send(8'hFB); idle(1);
        chk("neg5_lat", int'(bus.temp_latched), 251);
        chk("neg5_duty", int'(bus.fan_duty), 60);
        send(8'd35); idle(1);
        chk("t35_duty", int'(bus.fan_duty), 60);
        send(8'd69); idle(1);
        chk("t69_duty", int'(bus.fan_duty), 196);

        send(8'd40);
        s = cyc;
        idle(1);
        chk("t40_duty", int'(bus.fan_duty), 80);
        k = 0;
        while (!bus.fail_safe && k < 400) begin
            @(negedge clk0);
            k++;
            bus.temp_valid = (k % 16 == 0);
            bus.temp_data  = 8'h80;
        end
        bus.temp_valid = 1'b0;
        bus.temp_data  = 8'h00;
        chk("wd_latency", cyc - s, TO);
        chk("wd_fs", int'(bus.fail_safe), 1);
        chk("wd_duty", int'(bus.fan_duty), 222);

        send(8'd40); send(8'h80); send(8'd40); idle(1);
        chk("fs_v_e_v_fs", int'(bus.fail_safe), 1);
        chk("fs_v_e_v_duty", int'(bus.fan_duty), 222);
        send(8'h80); send(8'd40);
        chk("fs_one_valid", int'(bus.fail_safe), 1);
        send(8'd40);
        chk("fs_exit_fs", int'(bus.fail_safe), 0);
        chk("fs_exit_lat", int'(bus.temp_latched), 40);
        chk("fs_exit_duty_n1", int'(bus.fan_duty), 222);
        idle(1);
        chk("fs_exit_duty_n2", int'(bus.fan_duty), 80);

        idle(197);
        send(8'd40);
        chk("expiry_valid_wins", int'(bus.fail_safe), 0);
`else
        send(8'd30);
        hold(8'd30, 1000);
        chk("slew_settle_60", int'(bus.fan_duty), 60);
        send(8'd80);
        idle(9);
        chk("slew_before_step", int'(bus.fan_duty), 60);
        idle(1);
        chk("slew_first_step", int'(bus.fan_duty), 61);
        idle(50);
        chk("slew_six_steps", int'(bus.fan_duty), 66);
        hold(8'd80, 700);
        send(8'd50);
        hold(8'd50, 400);
        chk("slew_reverse_120", int'(bus.fan_duty), 120);
        send(8'd80);
        idle(55);
        #2 rstn = 1'b0;
        #1;
        chk("ramp_rst_duty", int'(bus.fan_duty), 150);
        chk("ramp_rst_fs", int'(bus.fail_safe), 0);
        chk("ramp_rst_lat", int'(bus.temp_latched), 0);
        @(negedge clk0);
        rstn = 1'b1;
        send(8'd40);
`endif

        idle(100);
        #2 rstn = 1'b0;
        #1;
        chk("arst_duty", int'(bus.fan_duty), 150);
        chk("arst_fs", int'(bus.fail_safe), 0);
        chk("arst_lat", int'(bus.temp_latched), 0);
        @(negedge clk0);
        rstn = 1'b1;
        send(8'hFE);
        chk("post_rst_lat", int'(bus.temp_latched), 254);
`ifndef FAN_SLEW_EN
        idle(1);
        chk("post_rst_duty", int'(bus.fan_duty), 60);
`endif

        @(negedge clk0);
        #2 rstn = 1'b0;
        @(negedge clk0);
        rstn = 1'b1;
        idle(199);
        chk("init_wd_before", int'(bus.fail_safe), 0);
        idle(1);
        chk("init_wd_fs", int'(bus.fail_safe), 1);
        chk("init_wd_duty", int'(bus.fan_duty), 222);
        send(8'd40); send(8'd40);
        chk("init_wd_exit_fs", int'(bus.fail_safe), 0);
        chk("init_wd_exit_lat", int'(bus.temp_latched), 40);
        idle(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fan_duty_ctrl.md
# fan_duty_ctrl

Maps the periodic I2C temperature reading to the 8-bit duty value consumed by the fan PWM generator (period 222 counts of clk0, 7.8125 MHz). Sits between the temperature-sensor I2C controller, whose done pulse and read byte it samples, and the PWM stage, which it feeds.

Its functions:
- piecewise-linear temperature-to-duty curve
- falling-edge hysteresis
- sensor-loss watchdog with full-speed fail-safe
- optional slew limiting

## Interface
- T_LOW, 35: temperature (°C, signed) at or below which duty = DUTY_MIN
- T_HIGH, 70: temperature at or above which duty = DUTY_MAX
- DUTY_MIN, 60: floor duty
- DUTY_MAX, 222: ceiling duty; also the fail-safe duty
- DUTY_STEP, 4: duty counts added per °C above T_LOW
- DUTY_INIT, 150: duty from reset until the first valid sample
- HYST, 3: °C a falling reading must drop before it is accepted
- TIMEOUT_TICKS, 6250000: clk0 cycles without a valid sample before fail-safe (800 ms)
- SLEW_TICKS, 7812: clk0 cycles per 1-count duty step (FAN_SLEW_EN only)

Ports:
- clk0  in  1  system clock, 7.8125 MHz
- rstn  in  1  reset, asynchronous, active-low
- temp_valid  in  1  one-cycle pulse: temp_data holds a new reading
- temp_data  in  8  signed two's-complement °C; 8'h80 is the sensor error code
- fan_duty  out  8  duty to PWM generator
- fail_safe  out  1  high while in FAILSAFE
- temp_latched  out  8  currently accepted temperature

## Operation
- Reset values:
  - fan_duty = DUTY_INIT
  - fail_safe = 0
  - temp_latched = 0
  - state = INIT
  - watchdog counter = 0
  - valid-sample count = 0
- Valid sample: temp_valid=1 and temp_data≠8'h80.
  - Every valid sample clears the watchdog.
  - Error samples do not clear the watchdog.
- States:
  - INIT:
    - fan_duty held at DUTY_INIT.
    - First valid sample loads temp_latched unconditionally → RUN.
    - Watchdog reaching TIMEOUT_TICKS → FAILSAFE.
  - RUN:
    - Valid sample loads temp_latched if new > temp_latched, or new ≤ temp_latched − HYST.
    - Compare in signed 9-bit arithmetic; no wrap.
    - Otherwise temp_latched is unchanged.
    - Watchdog reaching TIMEOUT_TICKS → FAILSAFE.
  - FAILSAFE:
    - fail_safe=1; fan_duty=DUTY_MAX immediately, with no slew.
    - Each valid sample increments the count; an error sample clears it.
    - On the second consecutive valid sample: load temp_latched unconditionally, clear fail_safe → RUN.
- Target curve (from temp_latched, computed 10-bit unsigned):
  - temp_latched negative or ≤ T_LOW → DUTY_MIN
  - temp_latched ≥ T_HIGH → DUTY_MAX
  - otherwise DUTY_MIN + (temp_latched − T_LOW)·DUTY_STEP, clamped to DUTY_MAX
- In RUN, fan_duty follows the target, directly or slew-limited (see Configuration).

## Timing
- temp_valid at edge N → temp_latched updated at N+1 → fan_duty updated at N+2 (no slew).
- Watchdog:
  - Counts every cycle outside FAILSAFE.
  - Entry to FAILSAFE occurs on the edge where the count reaches TIMEOUT_TICKS; fail_safe and fan_duty change on that same edge.
  - A valid sample on the expiry cycle wins: watchdog cleared, no FAILSAFE entry.
- FAILSAFE → RUN: temp_latched and fail_safe update at N+1 after the second valid pulse; fan_duty at N+2.
- rstn low at any time: all outputs return to reset values asynchronously; any ramp or timeout in progress is discarded.

## Configuration
- FAN_SLEW_EN defined:
  - In RUN, fan_duty moves toward the target by exactly 1 count per SLEW_TICKS cycles.
  - The slew counter restarts whenever fan_duty equals the target.
  - The first step occurs SLEW_TICKS cycles after the target first differs.
  - A target reversal mid-ramp changes direction at the next step.
  - INIT and FAILSAFE values are applied without slew.
- FAN_SLEW_EN undefined:
  - fan_duty = target registered (N+2 latency).
  - No slew counter is synthesised.

## Test plan
- Macro off, reset, valid 50 (8'h32) → temp_latched 50 at N+1, fan_duty 120 at N+2, fail_safe 0.
- Hysteresis: from 50/120, send 48 → fan_duty stays 120; send 47 → temp_latched 47, fan_duty 108; send 80 → fan_duty 222.
- Extremes: send 80 → 222; then −5 (8'hFB) → fan_duty 60; send 35 → 60; send 69 → 196.
- Watchdog:
  - Valid 40 → 80; then only 8'h80 samples → fail_safe=1 and fan_duty 222 exactly TIMEOUT_TICKS cycles after the last valid pulse.
  - Sequence valid, error, valid → still FAILSAFE.
  - Two further consecutive valid 40 → RUN, fan_duty 80.
- Macro on: at 60, send 80 → fan_duty 61 after 7812 cycles, 222 after 162·7812 cycles; send 50 mid-ramp → ramp reverses toward 120.
- Assert rstn low mid-ramp and mid-timeout → fan_duty 150, fail_safe 0, temp_latched 0 immediately; the first valid sample after release is accepted unconditionally.
